// File: rtl/cpu_sram_arbiter.sv
// Arbitrates one sram-like memory port between instruction fetch and data access.
// Data has priority, an unaccepted request is locked, and an in-order owner FIFO routes responses.
module cpu_sram_arbiter #(
  parameter int OUTSTANDING = 4,
  parameter int PTR_W       = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {SEL_NONE, SEL_INST, SEL_DATA} sel_t;

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(OUTSTANDING);

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic             owner_q [OUTSTANDING];  // 1 = data, 0 = inst
  logic             lock_vld;
  logic             lock_owner;
  sel_t             sel;
  logic             full;
  logic             push;
  logic             pop;
  logic             head_owner;

  assign full = (count == FULL_COUNT);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    sel       = SEL_NONE;
    mem_req   = 1'b0;
    mem_wr    = 1'b0;
    mem_wstrb = 4'h0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    if (lock_vld)      sel = lock_owner ? SEL_DATA : SEL_INST;
    else if (data_req) sel = SEL_DATA;
    else if (inst_req) sel = SEL_INST;
    case (sel)
      SEL_DATA: begin
        mem_req   = data_req;
        mem_wr    = data_wr;
        mem_wstrb = data_wstrb;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
      end
      SEL_INST: begin
        mem_req  = inst_req;
        mem_addr = inst_addr;
      end
      default: ;
    endcase
    // A full FIFO blocks issue even if a response pops in the same cycle.
    if (full || reset) mem_req = 1'b0;
  end

  assign push         = mem_req && mem_addr_ok;
  assign inst_addr_ok = push && (sel == SEL_INST);
  assign data_addr_ok = push && (sel == SEL_DATA);

  assign head_owner   = owner_q[rd_ptr];
  assign pop          = mem_data_ok && (count != '0) && !reset;
  assign inst_data_ok = pop && !head_owner;
  assign data_data_ok = pop && head_owner;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      lock_vld   <= 1'b0;
      lock_owner <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (mem_req) begin
        lock_vld   <= !mem_addr_ok;
        lock_owner <= (sel == SEL_DATA);
      end
    end
  end

  // NOTE: owner storage needs no reset; only entries between rd_ptr and wr_ptr are ever read.
  always_ff @(posedge clk) begin
    if (push) owner_q[wr_ptr] <= (sel == SEL_DATA);
  end

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
// Random two-master traffic against a transaction-level arbitration model and a response scoreboard.
module tb_cpu_sram_arbiter;

  localparam int OUT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  cpu_sram_arbiter #(.OUTSTANDING(OUT), .PTR_W(2)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          owner;  // 1 = data
    logic [31:0] rdata;
  } resp_t;

  int    n_cmp = 0;
  int    n_bad = 0;
  bit    oq[$];          // owners of accepted, unanswered requests, oldest first
  resp_t exp_q[$];       // responses the memory is returning this cycle
  bit    lock_m, lock_own_m;
  bit    inst_acc, data_acc;
  resp_t mon_r;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Response monitor: every data_ok must match the response the memory just returned.
  always @(negedge clk) begin
    if (exp_q.size() == 0) begin
      check("no_data_ok", {30'b0, inst_data_ok, data_data_ok}, 32'h0);
    end else begin
      mon_r = exp_q.pop_front();
      check("resp_route", {30'b0, inst_data_ok, data_data_ok}, mon_r.owner ? 32'h1 : 32'h2);
      check("resp_rdata", mon_r.owner ? data_rdata : inst_rdata, mon_r.rdata);
    end
  end

  task automatic new_inst();
    inst_req  = ($urandom_range(0, 99) < 60);
    inst_addr = $urandom & 32'hFFFF_FFFC;
  endtask

  task automatic new_data();
    data_req   = ($urandom_range(0, 99) < 45);
    data_wr    = $urandom_range(0, 1) == 1;
    data_wstrb = 4'($urandom_range(0, 15));
    data_addr  = $urandom;
    data_wdata = $urandom;
  endtask

  task automatic run_cycle(input int p_aok, input int p_dok);
    bit    full_m, exp_req;
    int    sel;  // 0 none, 1 inst, 2 data
    resp_t r;
    @(posedge clk); #1;
    full_m = (oq.size() == OUT);
    if (!inst_req || inst_acc) new_inst();
    if (!data_req || data_acc) new_data();
    inst_acc    = 1'b0;
    data_acc    = 1'b0;
    mem_addr_ok = ($urandom_range(0, 99) < p_aok);
    mem_data_ok = 1'b0;
    if ($urandom_range(0, 99) < p_dok) begin
      mem_data_ok = 1'b1;
      mem_rdata   = $urandom;
      if (oq.size() != 0) begin
        r.owner = oq.pop_front();
        r.rdata = mem_rdata;
        exp_q.push_back(r);
      end
    end
    if (lock_m)        sel = lock_own_m ? 2 : 1;
    else if (data_req) sel = 2;
    else if (inst_req) sel = 1;
    else               sel = 0;
    exp_req = !full_m && (sel != 0);
    @(negedge clk);
    check("mem_req", {31'b0, mem_req}, {31'b0, exp_req});
    check("inst_addr_ok", {31'b0, inst_addr_ok}, {31'b0, exp_req && mem_addr_ok && sel == 1});
    check("data_addr_ok", {31'b0, data_addr_ok}, {31'b0, exp_req && mem_addr_ok && sel == 2});
    if (exp_req) begin
      check("mem_addr",  mem_addr, (sel == 2) ? data_addr : inst_addr);
      check("mem_wr",    {31'b0, mem_wr}, (sel == 2) ? {31'b0, data_wr} : 32'h0);
      check("mem_wstrb", {28'b0, mem_wstrb}, (sel == 2) ? {28'b0, data_wstrb} : 32'h0);
      check("mem_wdata", mem_wdata, (sel == 2) ? data_wdata : 32'h0);
      if (mem_addr_ok) begin
        oq.push_back(sel == 2);
        lock_m = 1'b0;
        if (sel == 2) data_acc = 1'b1;
        else          inst_acc = 1'b1;
      end else begin
        lock_m     = 1'b1;
        lock_own_m = (sel == 2);
      end
    end
  endtask

  // Reset with requests and a stale response pending; everything in flight is discarded.
  task automatic apply_reset(input int n);
    @(posedge clk); #1;
    reset       = 1'b1;
    oq.delete();
    lock_m      = 1'b0;
    inst_acc    = 1'b0;
    data_acc    = 1'b0;
    mem_addr_ok = 1'b1;
    mem_data_ok = 1'b1;
    mem_rdata   = $urandom;
    repeat (n) begin
      @(negedge clk);
      check("rst_mem_req",      {31'b0, mem_req},      32'h0);
      check("rst_inst_addr_ok", {31'b0, inst_addr_ok}, 32'h0);
      check("rst_data_addr_ok", {31'b0, data_addr_ok}, 32'h0);
    end
    inst_req    = 1'b0;
    data_req    = 1'b0;
    mem_data_ok = 1'b0;
    reset       = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    inst_req    = 1'b1;
    inst_addr   = 32'h0000_1000;
    data_req    = 1'b1;
    data_wr     = 1'b1;
    data_wstrb  = 4'hF;
    data_addr   = 32'h0000_2000;
    data_wdata  = 32'hDEAD_BEEF;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = 32'h0;
    lock_m      = 1'b0;
    lock_own_m  = 1'b0;
    inst_acc    = 1'b0;
    data_acc    = 1'b0;
    apply_reset(2);
    repeat (1500) run_cycle(70, 15);  // slow responses: FIFO fills often
    apply_reset(2);
    repeat (1500) run_cycle(50, 60);  // frequent stalls: exercises the lock
    apply_reset(3);
    repeat (1000) run_cycle(90, 40);
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
